// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin tri-state bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned TCNT_W = 2;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational wrap-around search: first set req bit strictly after ptr, modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // Scan from farthest to nearest so the nearest hit after ptr is the one kept.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = int'(N); k >= 1; k--) begin
      if (req[IW'((int'(ptr) + k) % int'(N))]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % int'(N));
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared tri-state data bus: registered one-hot
// grant, bounded tenure, and dead cycles between owners.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           last,
  output logic [N_REQ-1:0]           grant,
  output logic                       owner_valid,
  output logic [idx_w(N_REQ)-1:0]    owner_id,
  output logic                       bus_busy
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BEATS + 1);

  state_t            state, state_nxt;
  logic [BW-1:0]     beat_cnt, beat_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic [IW-1:0]     rr_ptr, ptr_nxt, id_nxt;
  logic [N_REQ-1:0]  grant_nxt;
  logic              valid_nxt, busy_nxt;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic              tenure_end;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Drop, last beat and the beat cap all collapse into one release.
  assign tenure_end = !req[owner_id] || last[owner_id] || (beat_cnt == BW'(MAX_BEATS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      tcnt        <= '0;
      rr_ptr      <= IW'(N_REQ - 1);
      grant       <= '0;
      owner_id    <= '0;
      owner_valid <= 1'b0;
      bus_busy    <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_nxt;
      tcnt        <= tcnt_nxt;
      rr_ptr      <= ptr_nxt;
      grant       <= grant_nxt;
      owner_id    <= id_nxt;
      owner_valid <= valid_nxt;
      bus_busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_found) state_nxt = ST_GRANT;
      ST_GRANT: if (tenure_end) state_nxt = (TURNAROUND == 0) ? ST_IDLE : ST_TURN;
      ST_TURN:  if (tcnt <= TCNT_W'(1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_nxt  = beat_cnt;
    tcnt_nxt  = tcnt;
    ptr_nxt   = rr_ptr;
    grant_nxt = grant;
    id_nxt    = owner_id;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_onehot;
          id_nxt    = pick_idx;
          ptr_nxt   = pick_idx;
          beat_nxt  = BW'(1);
        end
      end
      ST_GRANT: begin
        if (tenure_end) begin
          grant_nxt = '0;
          id_nxt    = '0;
          beat_nxt  = '0;
          tcnt_nxt  = TCNT_W'(TURNAROUND);
        end else begin
          beat_nxt  = beat_cnt + BW'(1);
        end
      end
      ST_TURN: tcnt_nxt = (tcnt > TCNT_W'(1)) ? tcnt - TCNT_W'(1) : '0;
      default: begin
        grant_nxt = '0;
        id_nxt    = '0;
        beat_nxt  = '0;
        tcnt_nxt  = '0;
      end
    endcase
    valid_nxt = |grant_nxt;
    busy_nxt  = (state_nxt != ST_IDLE);
  end

  a_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(grant));
  a_no_swap: assert property (@(posedge clock) disable iff (!reset_n)
    (grant != '0 && $past(grant) != '0) |-> grant == $past(grant));
  a_id: assert property (@(posedge clock) disable iff (!reset_n)
    owner_valid |-> grant == (N_REQ'(1) << owner_id));

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed checks of bus_arbiter against a tenure-level reference model.
module tb_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req, last;
  logic [3:0] grant_a, grant_b;
  logic       valid_a, valid_b, busy_a, busy_b;
  logic [1:0] id_a, id_b;

  int checks = 0;
  int failures = 0;

  // Model per instance: 0 = default (T=1, MB=16), 1 = fast path (T=0, MB=2).
  int m_owner[2], m_beats[2], m_dead[2], m_prev[2];
  int p_t[2]  = '{1, 0};
  int p_mb[2] = '{16, 2};

  bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_BEATS(16)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .last(last),
    .grant(grant_a), .owner_valid(valid_a), .owner_id(id_a), .bus_busy(busy_a));

  bus_arbiter #(.N_REQ(4), .TURNAROUND(0), .MAX_BEATS(2)) dut_fast (
    .clock(clock), .reset_n(reset_n), .req(req), .last(last),
    .grant(grant_b), .owner_valid(valid_b), .owner_id(id_b), .bus_busy(busy_b));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_beats[m] = 0;
      m_dead[m]  = 0;
      m_prev[m]  = 3;
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] r, input logic [3:0] l);
    bit done;
    int c;
    if (m_owner[m] >= 0) begin
      if (!r[m_owner[m]] || l[m_owner[m]] || m_beats[m] == p_mb[m]) begin
        m_owner[m] = -1;
        m_dead[m]  = p_t[m];
      end else begin
        m_beats[m]++;
      end
    end else if (m_dead[m] > 0) begin
      m_dead[m]--;
    end else begin
      done = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_prev[m] + k) % 4;
        if (!done && r[c]) begin
          done       = 1'b1;
          m_owner[m] = c;
          m_prev[m]  = c;
          m_beats[m] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] g;
    logic       v, b;
    logic [1:0] id;
    for (int m = 0; m < 2; m++) begin
      g  = (m == 0) ? grant_a : grant_b;
      v  = (m == 0) ? valid_a : valid_b;
      b  = (m == 0) ? busy_a  : busy_b;
      id = (m == 0) ? id_a    : id_b;
      check($sformatf("grant[%0d]", m), 32'(g),
            (m_owner[m] >= 0) ? (32'd1 << m_owner[m]) : 32'd0);
      check($sformatf("owner_valid[%0d]", m), 32'(v), 32'(m_owner[m] >= 0));
      check($sformatf("owner_id[%0d]", m), 32'(id),
            (m_owner[m] >= 0) ? 32'(m_owner[m]) : 32'd0);
      check($sformatf("bus_busy[%0d]", m), 32'(b),
            32'(m_owner[m] >= 0 || m_dead[m] > 0));
    end
  endtask

  // Compare the current cycle, then present inputs for the coming edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l);
    @(negedge clock);
    check_outputs();
    req  = r;
    last = l;
    model_step(0, r, l);
    model_step(1, r, l);
  endtask

  // Reset lands between edges while a tenure is live; grant must fall at once.
  task automatic async_reset();
    @(posedge clock);
    #1 check_outputs();
    #1 reset_n = 1'b0;
    req  = '0;
    last = '0;
    model_reset();
    #1 check_outputs();
    check("async_grant_a", 32'(grant_a), 32'd0);
    check("async_grant_b", 32'(grant_b), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r, l;
    int o;
    reset_n = 1'b0;
    req     = '0;
    last    = '0;
    model_reset();
    #12 check_outputs();
    @(negedge clock);
    reset_n = 1'b1;

    // Single owner, last on the third grant cycle.
    for (int i = 0; i < 10; i++) begin
      l = (m_owner[0] == 0 && m_beats[0] == 3) ? 4'b0001 : 4'b0000;
      step(4'b0001, l);
    end
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // All requesting, each owner ends on its first beat.
    for (int i = 0; i < 20; i++) begin
      l = (m_owner[0] >= 0) ? 4'(1 << m_owner[0]) : 4'b0000;
      step(4'b1111, l);
    end

    // Forced release at the beat cap, then a contender.
    for (int i = 0; i < 40; i++) step(4'b0100, 4'b0000);
    for (int i = 0; i < 40; i++) step(4'b0110, 4'b0000);

    // Reset mid-tenure, then priority restarts from requester 0.
    for (int i = 0; i < 4; i++) step(4'b0001, 4'b0000);
    async_reset();
    for (int i = 0; i < 6; i++) step(4'b1000, 4'b0000);
    for (int i = 0; i < 4; i++) step(4'b0010, 4'b0000);
    async_reset();
    for (int i = 0; i < 6; i++) step(4'b1001, 4'b0000);

    // Drop and last together on the owner, plus a stray last on a neighbour.
    for (int i = 0; i < 40; i++) begin
      r = 4'b1111;
      l = 4'b0000;
      if (m_owner[0] >= 0 && m_beats[0] == 2) begin
        o = m_owner[0];
        r = r & ~4'(1 << o);
        l = 4'(1 << o) | 4'(1 << ((o + 1) % 4));
      end else if (m_owner[0] >= 0) begin
        l = 4'(1 << ((m_owner[0] + 2) % 4));
      end
      step(r, l);
    end

    // Fast-path pattern on two steady requesters.
    for (int i = 0; i < 12; i++) step(4'b0011, 4'b0000);

    // Random traffic with sticky requests.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      l = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(r, l);
      if ($urandom_range(499) == 0) async_reset();
    end
    step(4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
